// File: rtl/pll_lock_sequencer.sv
// Sequences RST/PWRDWN for a PLLE2_BASE, qualifies LOCKED, and issues READY.
// Handles timeout/retry and lock-loss re-lock. Runs on the PLL reference clock.
//
// state         | meaning
// --------------+----------------------------------------------------------
// S_RESET_HOLD  | PLL_RST asserted, counting out the minimum reset pulse
// S_WAIT_LOCK   | PLL_RST released, waiting for synchronized LOCKED
// S_STABLE      | LOCKED seen, requiring it to stay high for a qualify window
// S_RUN         | locked and qualified, READY asserted
// S_POWERDOWN   | PLL held powered down and in reset while PWRDWN_REQ is high
module pll_lock_sequencer #(
    parameter int RST_HOLD_CYCLES    = 16,
    parameter int LOCK_TIMEOUT       = 65536,
    parameter int LOCK_STABLE_CYCLES = 256
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       PLL_LOCKED,
    input  logic       REQ_RESET,
    input  logic       PWRDWN_REQ,
    output logic       PLL_RST,
    output logic       PLL_PWRDWN,
    output logic       READY,
    output logic       LOCK_LOST,
    output logic       TIMEOUT,
    output logic [7:0] RETRY_CNT
);

    localparam int MAX_AB  = (RST_HOLD_CYCLES > LOCK_TIMEOUT) ? RST_HOLD_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_ALL = (MAX_AB > LOCK_STABLE_CYCLES) ? MAX_AB : LOCK_STABLE_CYCLES;
    localparam int CW      = $clog2(MAX_ALL) + 1;

    localparam logic [CW-1:0] HOLD_LAST   = CW'(RST_HOLD_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST     = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_RESET_HOLD,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_POWERDOWN
    } state_t;

    state_t        state, next_state;
    logic [CW-1:0] cnt, cnt_next;
    logic          sync1, locked_s;
    logic          timeout_next, lost_next;

    // LOCKED is asynchronous to CLK; two flops before any decision uses it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1    <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync1    <= PLL_LOCKED;
            locked_s <= sync1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_RESET_HOLD;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        next_state   = state;
        cnt_next     = cnt;
        timeout_next = 1'b0;
        lost_next    = 1'b0;
        if (PWRDWN_REQ) begin
            next_state = S_POWERDOWN;
            cnt_next   = '0;
        end else if (REQ_RESET) begin
            next_state = S_RESET_HOLD;
            cnt_next   = '0;
        end else begin
            case (state)
                S_RESET_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        next_state = S_WAIT_LOCK;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    if (locked_s) begin
                        next_state = S_STABLE;
                        cnt_next   = '0;
                    end else if (cnt == TO_LAST) begin
                        next_state   = S_RESET_HOLD;
                        cnt_next     = '0;
                        timeout_next = 1'b1;
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end
                S_STABLE: begin
                    // A dropout during qualification restarts the lock wait, not a retry.
                    if (!locked_s) begin
                        next_state = S_WAIT_LOCK;
                        cnt_next   = '0;
                    end else if (cnt == STABLE_LAST) begin
                        next_state = S_RUN;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end
                S_RUN: begin
                    if (!locked_s) begin
                        next_state = S_RESET_HOLD;
                        cnt_next   = '0;
                        lost_next  = 1'b1;
                    end
                end
                S_POWERDOWN: begin
                    next_state = S_RESET_HOLD;
                    cnt_next   = '0;
                end
                default: begin
                    next_state = S_RESET_HOLD;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Outputs are registered from next_state so they change on the transition edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            PLL_RST    <= 1'b1;
            PLL_PWRDWN <= 1'b0;
            READY      <= 1'b0;
            LOCK_LOST  <= 1'b0;
            TIMEOUT    <= 1'b0;
            RETRY_CNT  <= 8'd0;
        end else begin
            PLL_RST    <= (next_state == S_RESET_HOLD) || (next_state == S_POWERDOWN);
            PLL_PWRDWN <= (next_state == S_POWERDOWN);
            READY      <= (next_state == S_RUN);
            LOCK_LOST  <= lost_next;
            TIMEOUT    <= timeout_next;
            if ((timeout_next || lost_next) && (RETRY_CNT != 8'hFF)) begin
                RETRY_CNT <= RETRY_CNT + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer: per-cycle vector table plus
// hand-written timeout, saturation and async-reset sequences.
module tb_pll_lock_sequencer;

    logic       CLK = 1'b0;
    logic       RST;
    logic       PLL_LOCKED;
    logic       REQ_RESET;
    logic       PWRDWN_REQ;
    logic       PLL_RST;
    logic       PLL_PWRDWN;
    logic       READY;
    logic       LOCK_LOST;
    logic       TIMEOUT;
    logic [7:0] RETRY_CNT;

    int checks = 0;
    int errors = 0;

    pll_lock_sequencer #(
        .RST_HOLD_CYCLES   (4),
        .LOCK_TIMEOUT      (32),
        .LOCK_STABLE_CYCLES(8)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .PLL_LOCKED(PLL_LOCKED),
        .REQ_RESET (REQ_RESET),
        .PWRDWN_REQ(PWRDWN_REQ),
        .PLL_RST   (PLL_RST),
        .PLL_PWRDWN(PLL_PWRDWN),
        .READY     (READY),
        .LOCK_LOST (LOCK_LOST),
        .TIMEOUT   (TIMEOUT),
        .RETRY_CNT (RETRY_CNT)
    );

    always #5 CLK = ~CLK;

    // {locked, req, pwr} in; exp = {pll_rst, pwrdwn, ready, lock_lost, timeout, retry[7:0]}
    typedef struct {
        logic        locked;
        logic        req;
        logic        pwr;
        logic [12:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [12:0] outs();
        return {PLL_RST, PLL_PWRDWN, READY, LOCK_LOST, TIMEOUT, RETRY_CNT};
    endfunction

    task automatic add(input int n, input logic l, input logic r, input logic p,
                       input logic e_rst, input logic e_pwr, input logic e_rdy,
                       input logic e_ll, input logic e_to, input logic [7:0] e_ret);
        vec_t v;
        v.locked = l;
        v.req    = r;
        v.pwr    = p;
        v.exp    = {e_rst, e_pwr, e_rdy, e_ll, e_to, e_ret};
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        // Edge numbering: edge 1 is the first rising edge after RST is released.
        add(3,  0, 0, 0, 1, 0, 0, 0, 0, 8'd0);  // edges 1-3 reset hold
        add(10, 0, 0, 0, 0, 0, 0, 0, 0, 8'd0);  // edges 4-13 wait lock
        add(10, 1, 0, 0, 0, 0, 0, 0, 0, 8'd0);  // edges 14-23 sync + stable
        add(6,  1, 0, 0, 0, 0, 1, 0, 0, 8'd0);  // edges 24-29 run
        add(2,  0, 0, 0, 0, 0, 1, 0, 0, 8'd0);  // edges 30-31 loss in sync
        add(1,  0, 0, 0, 1, 0, 0, 1, 0, 8'd1);  // edge 32 lock lost
        add(3,  0, 0, 0, 1, 0, 0, 0, 0, 8'd1);  // edges 33-35 reset hold
        add(1,  0, 0, 0, 0, 0, 0, 0, 0, 8'd1);  // edge 36 wait lock
        add(5,  1, 0, 0, 0, 0, 0, 0, 0, 8'd1);  // edges 37-41 glitchy lock
        add(1,  0, 0, 0, 0, 0, 0, 0, 0, 8'd1);  // edge 42 dropout
        add(10, 1, 0, 0, 0, 0, 0, 0, 0, 8'd1);  // edges 43-52 requalify
        add(4,  1, 0, 0, 0, 0, 1, 0, 0, 8'd1);  // edges 53-56 run
        add(3,  1, 1, 1, 1, 1, 0, 0, 0, 8'd1);  // edges 57-59 powerdown wins
        add(4,  1, 0, 0, 1, 0, 0, 0, 0, 8'd1);  // edges 60-63 reset hold
        add(3,  1, 0, 0, 0, 0, 0, 0, 0, 8'd1);  // edges 64-66 wait/stable
        add(1,  1, 1, 0, 1, 0, 0, 0, 0, 8'd1);  // edge 67 req_reset
        add(3,  1, 0, 0, 1, 0, 0, 0, 0, 8'd1);  // edges 68-70 reset hold
        add(1,  1, 0, 0, 0, 0, 0, 0, 0, 8'd1);  // edge 71 wait lock

        RST        = 1'b1;
        PLL_LOCKED = 1'b0;
        REQ_RESET  = 1'b0;
        PWRDWN_REQ = 1'b0;
        repeat (3) tick();
        check("reset_values", outs(), 13'h1000);
        RST = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            PLL_LOCKED = vecs[i].locked;
            REQ_RESET  = vecs[i].req;
            PWRDWN_REQ = vecs[i].pwr;
            tick();
            check($sformatf("vec_edge%0d", i + 1), outs(), vecs[i].exp);
        end

        // Timeout sequence from a fresh reset with LOCKED held low.
        PLL_LOCKED = 1'b0;
        REQ_RESET  = 1'b0;
        PWRDWN_REQ = 1'b0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        for (int e = 1; e < 144; e++) begin
            logic       e_rst;
            logic       e_to;
            logic [7:0] e_ret;
            e_rst = (e % 36) < 4;
            e_to  = (e % 36) == 0;
            e_ret = 8'(e / 36);
            tick();
            check($sformatf("timeout_edge%0d", e), outs(), {e_rst, 1'b0, 1'b0, 1'b0, e_to, e_ret});
        end
        REQ_RESET = 1'b1;   // coincides with the 4th timeout edge
        tick();
        check("req_beats_timeout", outs(), {1'b1, 4'b0000, 8'd3});
        REQ_RESET = 1'b0;

        // Saturation: each timeout period is 36 edges from a cleared RESET_HOLD.
        for (int i = 1; i <= 257; i++) begin
            logic [7:0] e_ret;
            e_ret = (3 + i > 255) ? 8'd255 : 8'(3 + i);
            repeat (36) tick();
            check($sformatf("sat_timeout%0d", i), {TIMEOUT, RETRY_CNT}, {1'b1, e_ret});
        end
        repeat (4) tick();
        check("sat_wait_lock", outs(), {1'b0, 4'b0000, 8'd255});

        // Asynchronous reset between edges must take effect without a clock.
        #2;
        RST = 1'b1;
        #1;
        check("async_reset", outs(), 13'h1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Control stage directly upstream of the PLLE2_BASE primitive. It drives the PLL's RST and PWRDWN pins and monitors LOCKED, then issues a single qualified READY to downstream reset logic. It sequences the minimum RST pulse, times out and retries when lock never arrives, and forces a full re-lock on lock loss. It runs on the free-running reference clock that also feeds CLKIN1.

## Interface
- RST_HOLD_CYCLES, 16: PLL_RST high time per reset attempt, in CLK cycles; must be ≥1.
- LOCK_TIMEOUT, 65536: maximum cycles spent in WAIT_LOCK before a retry; must be ≥2.
- LOCK_STABLE_CYCLES, 256: consecutive synchronized-locked cycles required before READY; must be ≥1.
- Internal counter width: $clog2 of the largest of the three parameters, plus 1.

Ports:
- CLK  in  1  reference clock, same net as the PLL's CLKIN1.
- RST  in  1  asynchronous, active-high reset for the whole block.
- PLL_LOCKED  in  1  PLL LOCKED pin; asynchronous to CLK, double-flop synchronized internally.
- REQ_RESET  in  1  synchronous level/pulse; requests a re-lock.
- PWRDWN_REQ  in  1  synchronous level; holds the PLL powered down.
- PLL_RST  out  1  drives the PLL RST pin.
- PLL_PWRDWN  out  1  drives the PLL PWRDWN pin.
- READY  out  1  PLL locked and stable; downstream may release its resets.
- LOCK_LOST  out  1  one-cycle pulse when lock drops while in RUN.
- TIMEOUT  out  1  one-cycle pulse when a WAIT_LOCK timeout fires.
- RETRY_CNT  out  8  count of timeouts plus lock losses; saturates at 255; cleared only by RST.

## Operation
- All outputs are registered.
- Reset values while RST is high:
  - State RESET_HOLD, counter 0.
  - PLL_RST=1, PLL_PWRDWN=0, READY=0, LOCK_LOST=0, TIMEOUT=0, RETRY_CNT=0.
  - Both synchronizer flops 0.
- locked_s is the output of the second synchronizer flop.
- Priority evaluated each edge, in any state: PWRDWN_REQ > REQ_RESET > per-state rules.
- PWRDWN_REQ=1: go to POWERDOWN.
- REQ_RESET=1 (and PWRDWN_REQ=0): go to RESET_HOLD with counter cleared. RETRY_CNT is not incremented.
- States and transitions:
  - RESET_HOLD: PLL_RST=1. Counter increments. When counter==RST_HOLD_CYCLES-1, go to WAIT_LOCK and clear the counter.
  - WAIT_LOCK: PLL_RST=0.
    - If locked_s=1, go to STABLE and clear the counter.
    - Else if counter==LOCK_TIMEOUT-1, go to RESET_HOLD, pulse TIMEOUT, increment RETRY_CNT.
  - STABLE: PLL_RST=0.
    - If locked_s=0, go to WAIT_LOCK and clear the counter. The timeout restarts; this is not a retry.
    - Else if counter==LOCK_STABLE_CYCLES-1, go to RUN.
  - RUN: READY=1. If locked_s=0, go to RESET_HOLD, pulse LOCK_LOST, increment RETRY_CNT.
  - POWERDOWN: PLL_PWRDWN=1, PLL_RST=1, READY=0. When PWRDWN_REQ=0, go to RESET_HOLD with counter cleared.
- READY is registered as (next_state==RUN). It therefore rises on the same edge the FSM enters RUN and falls on the same edge it leaves RUN.
- RETRY_CNT increment saturates: 255 stays 255.
- If TIMEOUT and REQ_RESET fire on the same edge, REQ_RESET wins: no TIMEOUT pulse, no increment.

## Timing
- After RST deasserts, PLL_RST stays 1 for exactly RST_HOLD_CYCLES rising edges, then falls.
- PLL_LOCKED to FSM latency: a pin change first sampled at edge k is acted on at edge k+2.
- READY rises LOCK_STABLE_CYCLES edges after the edge that entered STABLE.
- Lock loss in RUN: READY, PLL_RST and LOCK_LOST all change on the same edge, i.e. edge k+2 after the pin falls.
- An asynchronous RST assertion mid-operation forces the reset values immediately, with no clock needed.
- Glitches on PLL_LOCKED shorter than one cycle that miss a sampling edge are ignored by construction.

## Test plan
Parameters for all tests: RST_HOLD_CYCLES=4, LOCK_TIMEOUT=32, LOCK_STABLE_CYCLES=8.
- Normal lock:
  - Stimulus: release RST; assert PLL_LOCKED 10 cycles after PLL_RST falls and hold it.
  - Response: PLL_RST high exactly 4 edges. READY rises 2+8 edges after the first sampling edge of LOCKED. RETRY_CNT=0.
- Timeout:
  - Stimulus: keep PLL_LOCKED=0.
  - Response: TIMEOUT pulses every 4+32 cycles and PLL_RST re-pulses each time. RETRY_CNT reaches 3 after 3 timeouts.
- Unstable lock:
  - Stimulus: LOCKED high for 5 cycles, low for 1, then high.
  - Response: no READY during the glitch window. READY rises 8 edges after re-entering STABLE. RETRY_CNT unchanged.
- Lock loss in RUN:
  - Stimulus: drop PLL_LOCKED while READY=1.
  - Response: at edge k+2, READY=0, LOCK_LOST=1 for 1 cycle, PLL_RST=1, RETRY_CNT+1.
- Priority:
  - Stimulus: assert PWRDWN_REQ and REQ_RESET together in RUN.
  - Response: PLL_PWRDWN=1, PLL_RST=1, READY=0. After PWRDWN_REQ drops, a 4-cycle RST hold follows.
- Saturation and async reset:
  - Stimulus: force 260 timeouts; then assert RST between clock edges.
  - Response: RETRY_CNT stops at 255. On RST, all outputs return to their reset values immediately.
